// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of RAM words out as a valid/ready stream, hiding the
// address-register and registered-read latency behind a small credit-limited FIFO.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE_WORD   = (ADDR_WIDTH+1)'(1);
    localparam logic [2:0]          FIFO_DEPTH = 3'd4;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   beats_left;
    logic [2:0]            credit;
    logic [1:0]            inflight_valid;
    logic [1:0]            inflight_last;

    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic                  fifo_last [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;

    logic accept_start;
    logic start_issue;
    logic run_issue;
    logic issue;
    logic issue_last;
    logic push;
    logic pop;

    // The very first read goes out on the same edge that captures start, which is
    // what lets ram_raddr show start_addr one cycle after the request.
    assign accept_start = start && (state != RUN);
    assign start_issue  = accept_start && (length != '0);
    assign pop          = out_valid && out_ready;
    assign run_issue    = (state == RUN) && (remaining != '0) &&
                          ((credit < FIFO_DEPTH) || pop);
    assign issue        = start_issue || run_issue;
    assign issue_addr   = start_issue ? start_addr : next_addr;
    assign issue_last   = start_issue ? (length == ONE_WORD) : (remaining == ONE_WORD);
    assign push         = inflight_valid[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (pop && (beats_left == ONE_WORD)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_raddr  <= '0;
            next_addr  <= '0;
            remaining  <= '0;
            beats_left <= '0;
        end else begin
            if (issue) begin
                ram_raddr <= issue_addr;
                next_addr <= issue_addr + 1'b1;
            end
            if (accept_start) begin
                remaining  <= (length == '0) ? '0 : length - ONE_WORD;
                beats_left <= length;
            end else begin
                if (run_issue) begin
                    remaining <= remaining - ONE_WORD;
                end
                if (pop) begin
                    beats_left <= beats_left - ONE_WORD;
                end
            end
        end
    end

    // Credits cover both reads still in the RAM pipeline and words parked in the
    // FIFO, so four credits can never overfill the four FIFO slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit         <= '0;
            inflight_valid <= '0;
            inflight_last  <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credit <= credit + 3'd1;
                2'b01:   credit <= credit - 3'd1;
                default: credit <= credit;
            endcase
            inflight_valid <= {inflight_valid[0], issue};
            inflight_last  <= {inflight_last[0], issue && issue_last};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= inflight_last[1];
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        out_valid = (fifo_count != '0);
        out_data  = out_valid ? fifo_data[rd_ptr] : '0;
        out_last  = out_valid && fifo_last[rd_ptr];
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a behavioural RAM plus a queue model of the expected
// beat sequence, with directed latency/wrap/stall/reset cases and random transfers.
module tb_ram_stream_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NWORDS = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] mem [NWORDS];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ready_mode = 0;

    beat_t         exp_q [$];
    logic [DW-1:0] got_q [$];
    int beat_count, last_count, done_count, done_base;
    int first_beat_cyc, last_beat_cyc, done_cyc, start_cyc;
    int raddr_changes;
    logic [AW-1:0] prev_raddr;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_raddr  (ram_raddr),
        .ram_dout   (ram_dout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM, same behaviour as the dual_port_ram read port
    always @(posedge clk) ram_dout <= mem[ram_raddr];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [63:0] gotAt(input int i);
        if (i < got_q.size()) return 64'(got_q[i]);
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // Compare process: every valid head must match the model's next expected beat
    always @(negedge clk) begin
        if (reset) begin
            prev_raddr = ram_raddr;
        end else begin
            if (ram_raddr != prev_raddr) raddr_changes++;
            prev_raddr = ram_raddr;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("beat_data", 64'(out_data), 64'(exp_q[0].data));
                    checkOutput("beat_last", 64'(out_last), 64'(exp_q[0].last));
                    if (out_ready) begin
                        got_q.push_back(out_data);
                        if (out_last) last_count++;
                        if (first_beat_cyc < 0) first_beat_cyc = cyc;
                        last_beat_cyc = cyc;
                        beat_count++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                checkOutput("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input int sa, input int len);
        beat_t b;
        @(posedge clk);
        #1;
        beat_count     = 0;
        last_count     = 0;
        first_beat_cyc = -1;
        raddr_changes  = 0;
        done_base      = done_count;
        got_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = mem[(sa + i) % NWORDS];
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        start      = 1'b1;
        start_addr = AW'(sa % NWORDS);
        length     = (AW+1)'(len);
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int len, input int limit);
        int i = 0;
        while (done_count == done_base && i < limit) begin
            @(posedge clk);
            i++;
        end
        if (done_count == done_base) begin
            checkOutput("done_timeout", 64'(done_count - done_base), 64'd1);
            reset = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_pulses", 64'(done_count - done_base), 64'd1);
        checkOutput("model_leftover", 64'(exp_q.size()), 64'd0);
        checkOutput("beat_count", 64'(beat_count), 64'(len));
    endtask

    initial begin
        int i;
        int sa, len;
        for (int k = 0; k < NWORDS; k++) mem[k] = 32'h1000 + k;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        out_ready  = 1'b1;
        done_count = 0;
        prev_raddr = '0;

        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_raddr", 64'(ram_raddr), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] basic 5-word transfer from address 3");
        ready_mode = 0;
        applyStimulus(3, 5);
        waitDone(5, 100);
        checkOutput("first_beat_latency", 64'(first_beat_cyc - start_cyc), 64'd3);
        checkOutput("last_beat_latency", 64'(last_beat_cyc - start_cyc), 64'd7);
        checkOutput("done_latency", 64'(done_cyc - start_cyc), 64'd8);
        checkOutput("first_word", gotAt(0), 64'h1003);
        checkOutput("last_word", gotAt(4), 64'h1007);
        checkOutput("last_flag_count", 64'(last_count), 64'd1);

        $display("[TB] address wrap-around");
        applyStimulus(30, 4);
        waitDone(4, 100);
        checkOutput("wrap_w0", gotAt(0), 64'h101E);
        checkOutput("wrap_w1", gotAt(1), 64'h101F);
        checkOutput("wrap_w2", gotAt(2), 64'h1000);
        checkOutput("wrap_w3", gotAt(3), 64'h1001);

        $display("[TB] backpressure stall");
        ready_mode = 1;
        applyStimulus(10, 8);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stall_raddr_updates", 64'(raddr_changes), 64'd4);
        checkOutput("stall_beats", 64'(beat_count), 64'd0);
        ready_mode = 3;
        waitDone(8, 500);
        checkOutput("stall_w0", gotAt(0), 64'h100A);
        checkOutput("stall_w7", gotAt(7), 64'h1011);

        $display("[TB] zero-length request and ignored restart");
        ready_mode = 0;
        applyStimulus(7, 0);
        @(negedge clk);
        checkOutput("zero_len_done", 64'(done), 64'd1);
        checkOutput("zero_len_busy", 64'(busy), 64'd0);
        checkOutput("zero_len_valid", 64'(out_valid), 64'd0);
        waitDone(0, 20);
        applyStimulus(12, 6);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("busy_during_run", 64'(busy), 64'd1);
        start      = 1'b1;
        start_addr = AW'(20);
        length     = (AW+1)'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(6, 200);
        checkOutput("ignored_start_w5", gotAt(5), 64'h1011);

        $display("[TB] reset mid-transfer");
        applyStimulus(5, 8);
        i = 0;
        while (beat_count < 2 && i < 50) begin
            @(posedge clk);
            i++;
        end
        checkOutput("reset_wait_beats", 64'(beat_count), 64'd2);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_done", 64'(done), 64'd0);
        checkOutput("mid_rst_raddr", 64'(ram_raddr), 64'd0);
        checkOutput("mid_rst_data", 64'(out_data), 64'd0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_last", 64'(out_last), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 2);
        waitDone(2, 100);
        checkOutput("post_rst_w0", gotAt(0), 64'h1000);
        checkOutput("post_rst_w1", gotAt(1), 64'h1001);

        $display("[TB] full-depth transfer");
        applyStimulus(0, 32);
        waitDone(32, 200);
        checkOutput("full_w31", gotAt(31), 64'h101F);
        checkOutput("full_last_count", 64'(last_count), 64'd1);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < NWORDS; k++) mem[k] = $urandom;
            sa  = $urandom_range(0, NWORDS - 1);
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NWORDS);
            ready_mode = (t % 3 == 0) ? 0 : 2;
            applyStimulus(sa, len);
            waitDone(len, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Reads a contiguous block of words out of a `dual_port_ram` instance through its read port and presents them as a valid/ready stream with backpressure.
- Absorbs the RAM's one-cycle registered read latency and the block's own address-register stage.
- Sustains one word per cycle when the sink is always ready.
- Sits between a RAM filled by a writer and a consumer such as a UART TX or DMA path.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: RAM address width; must match the attached RAM.
- `DATA_WIDTH`, default 32: word width; must match the attached RAM.

Ports:
- `clk`  in  1  single clock; also drives the attached RAM.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only when `busy`=0.
- `start_addr`  in  ADDR_WIDTH  first word address, captured with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, captured with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer end.
- `ram_raddr`  out  ADDR_WIDTH  registered read address to RAM `raddr`.
- `ram_dout`  in  DATA_WIDTH  RAM `dout`; valid one cycle after `ram_raddr`.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  sink ready; a beat transfers when `out_valid` and `out_ready` are both 1.
- `out_last`  out  1  marks the final beat; qualified by `out_valid`.

## Operation
- Output FIFO is 4 entries deep.
- Credit counter (0..4) = reads issued + entries buffered − beats popped.
- A read issues in a cycle when all of the following hold: state is RUN, remaining > 0, and credit < 4 (credit counted after this cycle's pop).
  - Issuing a read loads `ram_raddr` and increments the address modulo 2^ADDR_WIDTH, so wrap-around past the top address continues at 0.
- A 2-stage valid shift register tracks in-flight reads. When stage 2 is set, `ram_dout` is written into the FIFO. Issue is credit-limited, so the FIFO can never overflow.
- States:
  - IDLE:
    - `start`=1 with `length`≠0 captures the address and count → RUN.
    - `start`=1 with `length`=0 → DONE; no beats are produced.
  - RUN:
    - Issues reads as above.
    - When remaining = 0, no reads are in flight, FIFO is empty and the last beat has transferred → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `busy`=1 in RUN only. In DONE, `busy`=0 and `done`=1, so a `start` sampled in the DONE cycle is accepted.
- `start` while `busy`=1 is ignored; the captured parameters do not change.
- `out_data`/`out_valid` come from the FIFO head. `out_last`=1 when the head entry is beat number `length`.
- Once `out_valid` is asserted, `out_data` holds until accepted (AXI-style).
- Reset (any time, including mid-transfer):
  - All outputs go to 0 and state goes to IDLE.
  - FIFO, credits and in-flight flags clear.
  - In-flight RAM data is discarded.

## Timing
- Latency: `start` high in cycle N → `ram_raddr`=`start_addr` and `busy`=1 in cycle N+1 → `ram_dout` valid in N+2 → `out_valid`=1 and `out_data`=mem[start_addr] in N+3.
- With `out_ready` held at 1: one beat per cycle. A length-L transfer shows beats in cycles N+3..N+L+2, and `done`=1 in cycle N+L+3.
- With `out_ready` held at 0: exactly 4 reads issue, then issue stops. Each accepted beat allows one more read.
- Zero-length request: `done`=1 in cycle N+1, `busy` stays 0, `out_valid` stays 0.
- Reset values: `busy`=0, `done`=0, `ram_raddr`=0, `out_data`=0, `out_valid`=0, `out_last`=0.

## Test plan
- RAM preloaded mem[i]=0x1000+i, `start_addr`=3, `length`=5, `out_ready`=1.
  - Beats 0x1003..0x1007 in 5 consecutive cycles.
  - `out_last` on 0x1007 only.
  - `done` 1 cycle after the last beat.
- `ADDR_WIDTH`=5, `start_addr`=30, `length`=4 → beats mem[30], mem[31], mem[0], mem[1] (address wrap-around).
- `out_ready`=0 for 10 cycles during a `length`=8 transfer, then toggling 1/0 → exactly 4 `ram_raddr` updates while stalled; all 8 words arrive in order with no loss or duplication.
- `length`=0 → single `done` pulse at N+1; no `out_valid`. A second `start` during `busy`=1 is ignored: beat count equals the first `length`.
- Assert `reset` mid-transfer after 2 beats, then `start` a new transfer with `start_addr`=0, `length`=2.
  - All outputs are 0 during reset.
  - Only mem[0] and mem[1] appear; no stale data.
- Full-depth transfer: `length`=32 with `start_addr`=0 → 32 beats in order, and `done` asserts exactly once.
